mem_req_queue: RTL

Buffers address-translated load/store micro-ops leaving the address-generation stage and issues them in order to the single-ported data-memory interface. It squashes entries younger than a mispredicted branch, routes faulting ops to the result port without touching memory, and aligns and sign-extends returning load data before writeback. It sits between the address stage (upstream) and the data memory plus result bus (downstream).

---
 rtl/mem_req_queue.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_queue.sv
// In-order load/store request queue between address generation and a single-ported data memory.
// Squashes ops younger than a mispredicted branch, bypasses memory for faults, and aligns load data.
module mem_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_valid,
    input  logic [31:0] IN_addr,
    input  logic [31:0] IN_data,
    input  logic [3:0]  IN_wmask,
    input  logic        IN_isLoad,
    input  logic [1:0]  IN_shamt,
    input  logic [1:0]  IN_size,
    input  logic        IN_signExt,
    input  logic        IN_except,
    input  logic [5:0]  IN_sqN,
    input  logic [5:0]  IN_tagDst,
    input  logic [4:0]  IN_nmDst,
    input  logic        IN_branchTaken,
    input  logic [5:0]  IN_branchSqN,
    output logic        OUT_stall,
    output logic        OUT_memValid,
    input  logic        IN_memReady,
    output logic [31:0] OUT_memAddr,
    output logic [31:0] OUT_memData,
    output logic [3:0]  OUT_memWMask,
    output logic        OUT_memWe,
    input  logic [31:0] IN_memRData,
    output logic        OUT_resValid,
    output logic [31:0] OUT_resData,
    output logic        OUT_resExcept,
    output logic [5:0]  OUT_resSqN,
    output logic [5:0]  OUT_resTagDst,
    output logic [4:0]  OUT_resNmDst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wmask;
        logic        isLoad;
        logic [1:0]  shamt;
        logic [1:0]  size;
        logic        signExt;
        logic        except;
        logic [5:0]  sqN;
        logic [5:0]  tagDst;
        logic [4:0]  nmDst;
    } entry_t;

    entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pendValid_q;
    logic            pendIsLoad_q;
    logic            pendExcept_q;
    logic [1:0]      pendShamt_q;
    logic [1:0]      pendSize_q;
    logic            pendSignExt_q;
    logic [5:0]      pendSqN_q;
    logic [5:0]      pendTagDst_q;
    logic [4:0]      pendNmDst_q;

    logic            resValid_q;
    logic [31:0]     resData_q;
    logic            resExcept_q;
    logic [5:0]      resSqN_q;
    logic [5:0]      resTagDst_q;
    logic [4:0]      resNmDst_q;

    entry_t          headEnt;
    entry_t          newEnt;
    logic            notEmpty;
    logic            headLive;
    logic            doPop;
    logic            popLive;
    logic            doEnq;
    logic            headSquash;
    logic            pendSquash;

    // Sequence numbers wrap at 6 bits, so "younger" is a positive signed distance.
    function automatic logic isYounger(input logic [5:0] sqN, input logic [5:0] branchSqN);
        logic [5:0] diff;
        diff = sqN - branchSqN;
        return !diff[5] && (diff != 6'd0);
    endfunction

    function automatic logic [31:0] alignLoad(input logic [31:0] raw, input logic [1:0] shamt,
                                              input logic [1:0] size, input logic signExt);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = raw >> {shamt, 3'b000};
        case (size)
            2'd0:    result = {{24{signExt & shifted[7]}}, shifted[7:0]};
            2'd1:    result = {{16{signExt & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    assign newEnt = '{addr: IN_addr, data: IN_data, wmask: IN_wmask, isLoad: IN_isLoad,
                      shamt: IN_shamt, size: IN_size, signExt: IN_signExt, except: IN_except,
                      sqN: IN_sqN, tagDst: IN_tagDst, nmDst: IN_nmDst};

    assign headEnt    = ent_q[head_q];
    assign notEmpty   = count_q != '0;
    assign headLive   = notEmpty && valid_q[head_q];
    assign doPop      = notEmpty && (!valid_q[head_q] || headEnt.except || IN_memReady);
    assign popLive    = doPop && valid_q[head_q];
    assign headSquash = IN_branchTaken && isYounger(headEnt.sqN, IN_branchSqN);
    assign pendSquash = IN_branchTaken && isYounger(pendSqN_q, IN_branchSqN);
    assign doEnq      = IN_valid && (count_q != FULL_CNT)
                        && !(IN_branchTaken && isYounger(IN_sqN, IN_branchSqN));

    assign OUT_stall    = count_q >= STALL_CNT;
    assign OUT_memValid = headLive && !headEnt.except;
    assign OUT_memAddr  = headEnt.addr;
    assign OUT_memData  = headEnt.data;
    assign OUT_memWMask = headEnt.isLoad ? 4'h0 : headEnt.wmask;
    assign OUT_memWe    = !headEnt.isLoad;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(doEnq) - CW'(doPop);
        if (IN_branchTaken) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (isYounger(ent_q[i].sqN, IN_branchSqN)) valid_d[i] = 1'b0;
            end
        end
        if (doPop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (doEnq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doEnq) ent_q[tail_q] <= newEnt;
    end

    // A head squashed on its handshake edge still reaches memory but never enters the response stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendValid_q   <= 1'b0;
            pendIsLoad_q  <= 1'b0;
            pendExcept_q  <= 1'b0;
            pendShamt_q   <= 2'd0;
            pendSize_q    <= 2'd0;
            pendSignExt_q <= 1'b0;
            pendSqN_q     <= 6'd0;
            pendTagDst_q  <= 6'd0;
            pendNmDst_q   <= 5'd0;
            resValid_q    <= 1'b0;
            resData_q     <= 32'd0;
            resExcept_q   <= 1'b0;
            resSqN_q      <= 6'd0;
            resTagDst_q   <= 6'd0;
            resNmDst_q    <= 5'd0;
        end else begin
            pendValid_q <= popLive && !headSquash;
            if (popLive) begin
                pendIsLoad_q  <= headEnt.isLoad;
                pendExcept_q  <= headEnt.except;
                pendShamt_q   <= headEnt.shamt;
                pendSize_q    <= headEnt.size;
                pendSignExt_q <= headEnt.signExt;
                pendSqN_q     <= headEnt.sqN;
                pendTagDst_q  <= headEnt.tagDst;
                pendNmDst_q   <= headEnt.nmDst;
            end
            resValid_q <= pendValid_q && !pendSquash;
            if (pendValid_q) begin
                resData_q   <= (pendIsLoad_q && !pendExcept_q)
                               ? alignLoad(IN_memRData, pendShamt_q, pendSize_q, pendSignExt_q)
                               : 32'd0;
                resExcept_q <= pendExcept_q;
                resSqN_q    <= pendSqN_q;
                resTagDst_q <= pendTagDst_q;
                resNmDst_q  <= pendNmDst_q;
            end
        end
    end

    assign OUT_resValid  = resValid_q;
    assign OUT_resData   = resData_q;
    assign OUT_resExcept = resExcept_q;
    assign OUT_resSqN    = resSqN_q;
    assign OUT_resTagDst = resTagDst_q;
    assign OUT_resNmDst  = resNmDst_q;

endmodule
